game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles in PLAY before the turn is forfeited (used only with GAME_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port new_game  input  1  synchronous clear of the board, turn and result.
REQ-005 SHALL have port move_valid  input  1  a move request is present.
REQ-006 SHALL have port move_idx  input  4  target cell, 0..8 in row-major order.
REQ-007 SHALL have port move_ready  output  1  the controller accepts a move this cycle.
REQ-008 SHALL have port move_err  output  1  one-cycle pulse when a handshaked move is illegal.
REQ-009 SHALL have port board  output  18  cell i occupies bits [2i+1:2i]; 00 empty, 01 X, 11 O.
REQ-010 SHALL have port turn  output  1  0 means X to move, 1 means O to move.
REQ-011 SHALL have port winner  output  2  00 none, 01 X, 11 O, 10 draw.
REQ-012 SHALL have port game_over  output  1  high while in state DONE.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse when a turn is forfeited.

Function
REQ-014 SHALL implement a state machine with states PLAY, CHECK and DONE.
REQ-015 SHALL drive move_ready high only in PLAY and only when new_game is low.
REQ-016 SHALL, on a handshake with move_idx<=8 and that cell empty, write the mark for turn (01 or 11) into the cell at that edge and go to CHECK.
REQ-017 SHALL, on a handshake with move_idx>=9 or an occupied cell, leave the board and turn unchanged, pulse move_err in the next cycle and stay in PLAY.
REQ-018 SHALL, in CHECK, evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) against the updated board in one cycle.
REQ-019 SHALL, when a line holds three equal non-empty marks, set winner to that mark and go to DONE.
REQ-020 SHALL, when no line wins and all 9 cells are non-empty, set winner=10 and go to DONE; a win on the ninth move SHALL report the win, not a draw.
REQ-021 SHALL otherwise toggle turn and return to PLAY, so a move-to-move pitch is a minimum of 2 cycles.
REQ-022 SHALL ignore move_valid in CHECK and DONE, without asserting move_err.
REQ-023 SHALL hold board, turn and winner unchanged in DONE until new_game or reset.
REQ-024 SHALL treat new_game as taking priority over any move or timeout in the same cycle: board=0, turn=0, winner=00, state=PLAY at the next edge.

Reset
REQ-025 SHALL, while Reset_n is low, asynchronously force state=PLAY, board=0, turn=0, winner=00, move_err=0, timeout=0 and the timeout counter to 0.
REQ-026 SHALL, when reset is asserted mid-CHECK, discard the pending evaluation; the first edge after release SHALL start a clean game.

Configuration
REQ-027 SHALL, with GAME_TIMEOUT_EN defined, count PLAY cycles without an accepted legal move; when the count reaches TIMEOUT_CYCLES-1, the next edge SHALL toggle turn, clear the count and pulse timeout.
REQ-028 SHALL clear the timeout count on an accepted legal move, on new_game and on leaving PLAY; an illegal move SHALL NOT clear it.
REQ-029 SHALL, without GAME_TIMEOUT_EN, omit the counter entirely and tie timeout to 0.

Structure
REQ-030 SHALL place in package ttt_pkg: the cell encoding constants (N=00, X=01, O=11), the winner codes, the state enum and the 8-entry win-line index table.
REQ-031 SHALL instantiate one combinational sub-module, ttt_line_check (board in; win flag, winning mark and full flag out).

Verification
REQ-032 SHALL cover: X moves 0, O 3, X 1, O 4, X 2 -> after the last CHECK: winner=01, game_over=1, board[5:0]=010101.
REQ-033 SHALL cover: move 0 by X, then O requests 0 -> move_err pulses one cycle; turn stays 1; board unchanged.
REQ-034 SHALL cover: move_idx=12 -> move_err=1 for one cycle; state stays PLAY.
REQ-035 SHALL cover: sequence 0,1,2,4,3,5,7,6,8 -> winner=10 (draw), game_over=1.
REQ-036 SHALL cover: new_game and a legal move_valid in the same cycle -> board=0, turn=0, no write.
REQ-037 SHALL cover: with GAME_TIMEOUT_EN and TIMEOUT_CYCLES=4, no move for 4 PLAY cycles -> timeout pulse; turn changes 0->1.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell marks, winner codes, controller states,
// the eight winning lines and a cell extraction helper.
package ttt_pkg;

   localparam logic [1:0] CELL_N = 2'b00;
   localparam logic [1:0] CELL_X = 2'b01;
   localparam logic [1:0] CELL_O = 2'b11;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_X    = 2'b01;
   localparam logic [1:0] WIN_O    = 2'b11;
   localparam logic [1:0] WIN_DRAW = 2'b10;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Rows, then columns, then the two diagonals, as row-major cell indices.
   localparam logic [3:0] WIN_LINES [8][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   function automatic logic [1:0] cellAt(input logic [17:0] brd, input logic [3:0] idx);
      return 2'(brd >> {idx, 1'b0});
   endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Move handshake and game status bundle between a player/host and game_ctrl.
interface game_ctrl_if;

   logic        new_game;
   logic        move_valid;
   logic [3:0]  move_idx;
   logic        move_ready;
   logic        move_err;
   logic [17:0] board;
   logic        turn;
   logic [1:0]  winner;
   logic        game_over;
   logic        timeout;

   modport master (
      output new_game, move_valid, move_idx,
      input  move_ready, move_err, board, turn, winner, game_over, timeout
   );

   modport slave (
      input  new_game, move_valid, move_idx,
      output move_ready, move_err, board, turn, winner, game_over, timeout
   );

endinterface

// File: rtl/ttt_line_check.sv
// Combinational board evaluation: any completed line (and its mark) plus a
// board-full flag, used by the controller's single-cycle CHECK state.
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [17:0] board_i,
   output logic        winFlag_o,
   output logic [1:0]  winMark_o,
   output logic        full_o
);

   logic [1:0] cellA, cellB, cellC;

   always_comb begin
      winFlag_o = 1'b0;
      winMark_o = CELL_N;
      full_o    = 1'b1;
      cellA     = CELL_N;
      cellB     = CELL_N;
      cellC     = CELL_N;
      for (int c = 0; c < 9; c++) begin
         if (cellAt(board_i, 4'(c)) == CELL_N) full_o = 1'b0;
      end
      for (int l = 0; l < 8; l++) begin
         cellA = cellAt(board_i, WIN_LINES[l][0]);
         cellB = cellAt(board_i, WIN_LINES[l][1]);
         cellC = cellAt(board_i, WIN_LINES[l][2]);
         if ((cellA != CELL_N) && (cellA == cellB) && (cellB == cellC)) begin
            winFlag_o = 1'b1;
            winMark_o = cellA;
         end
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Tic-tac-toe controller: move handshake, one-cycle line check, win/draw detection.
// The turn-forfeit idle timer is only built when GAME_TIMEOUT_EN is defined.
module game_ctrl
   import ttt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic        clk,
   input logic        Reset_n,
   game_ctrl_if.slave bus
);

   state_t      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic        turn_q, turn_d;
   logic [1:0]  winner_q, winner_d;
   logic        moveErr_q;
   logic        moveReady, legalMove, illegalMove, forfeit;
   logic [1:0]  mark;
   logic        winFlag, boardFull;
   logic [1:0]  winMark;

   ttt_line_check uLineCheck (
      .board_i   (board_q),
      .winFlag_o (winFlag),
      .winMark_o (winMark),
      .full_o    (boardFull)
   );

   assign moveReady   = (state_q == PLAY) && !bus.new_game;
   assign mark        = turn_q ? CELL_O : CELL_X;
   assign legalMove   = moveReady && bus.move_valid && (bus.move_idx <= 4'd8)
                        && (cellAt(board_q, bus.move_idx) == CELL_N);
   assign illegalMove = moveReady && bus.move_valid && !legalMove;

`ifdef GAME_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] idleCnt_q, idleCnt_d;
   logic             timeout_q;

   // Idle means a PLAY cycle without an accepted legal move; illegal attempts still count.
   assign forfeit = moveReady && !legalMove && (idleCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      idleCnt_d = '0;
      if (moveReady && !legalMove && !forfeit) idleCnt_d = idleCnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         idleCnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         idleCnt_q <= idleCnt_d;
         timeout_q <= forfeit;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign forfeit     = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      board_d  = board_q;
      turn_d   = turn_q;
      winner_d = winner_q;
      if (bus.new_game) begin
         state_d  = PLAY;
         board_d  = '0;
         turn_d   = 1'b0;
         winner_d = WIN_NONE;
      end else begin
         case (state_q)
            PLAY: begin
               if (legalMove) begin
                  board_d = board_q | (18'(mark) << {bus.move_idx, 1'b0});
                  state_d = CHECK;
               end else if (forfeit) begin
                  turn_d = ~turn_q;
               end
            end
            CHECK: begin
               // A completed line takes precedence so a ninth-move win is not a draw.
               if (winFlag) begin
                  winner_d = winMark;
                  state_d  = DONE;
               end else if (boardFull) begin
                  winner_d = WIN_DRAW;
                  state_d  = DONE;
               end else begin
                  turn_d  = ~turn_q;
                  state_d = PLAY;
               end
            end
            DONE:    state_d = DONE;
            default: state_d = PLAY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= PLAY;
         board_q   <= '0;
         turn_q    <= 1'b0;
         winner_q  <= WIN_NONE;
         moveErr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         board_q   <= board_d;
         turn_q    <= turn_d;
         winner_q  <= winner_d;
         moveErr_q <= illegalMove;
      end
   end

   assign bus.move_ready = moveReady;
   assign bus.move_err   = moveErr_q;
   assign bus.board      = board_q;
   assign bus.turn       = turn_q;
   assign bus.winner     = winner_q;
   assign bus.game_over  = (state_q == DONE);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed game scenarios followed by random play,
// every cycle compared against a cell-array reference model of the game rules.
module tb_game_ctrl;

   localparam int TO_CYCLES = 4;
   localparam int PH_PLAY  = 0;
   localparam int PH_CHECK = 1;
   localparam int PH_DONE  = 2;

   logic clk = 1'b0;
   logic rstN;

   game_ctrl_if gameBus ();

   game_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
      .clk     (clk),
      .Reset_n (rstN),
      .bus     (gameBus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: cells hold 0 empty, 1 X, 2 O; winner 0 none, 1 X, 2 O, 3 draw.
   int cells [9];
   int mTurn, mPhase, mWinner, mIdle;
   bit mErr, mTo;
   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [17:0] modelBoard();
      logic [17:0] b = '0;
      for (int i = 0; i < 9; i++) begin
         if (cells[i] == 1) b = b | (18'b01 << (2 * i));
         if (cells[i] == 2) b = b | (18'b11 << (2 * i));
      end
      return b;
   endfunction

   function automatic logic [1:0] modelWinner();
      case (mWinner)
         1:       return 2'b01;
         2:       return 2'b11;
         3:       return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 9; i++) cells[i] = 0;
      mTurn   = 0;
      mPhase  = PH_PLAY;
      mWinner = 0;
      mIdle   = 0;
      mErr    = 1'b0;
      mTo     = 1'b0;
   endtask

   task automatic modelStep(input bit ng, input bit mv, input int idx);
      bit win, full;
      int mark, a, b, c;
      mErr = 1'b0;
      mTo  = 1'b0;
      if (ng) begin
         modelReset();
         return;
      end
      if (mPhase == PH_PLAY) begin
         if (mv && idx <= 8 && cells[idx] == 0) begin
            cells[idx] = mTurn + 1;
            mPhase     = PH_CHECK;
            mIdle      = 0;
         end else begin
            mErr = mv;
`ifdef GAME_TIMEOUT_EN
            if (mIdle == TO_CYCLES - 1) begin
               mTurn = 1 - mTurn;
               mIdle = 0;
               mTo   = 1'b1;
            end else begin
               mIdle++;
            end
`endif
         end
      end else if (mPhase == PH_CHECK) begin
         win  = 1'b0;
         mark = 0;
         full = 1'b1;
         for (int l = 0; l < 8; l++) begin
            a = cells[lines[l][0]];
            b = cells[lines[l][1]];
            c = cells[lines[l][2]];
            if (a != 0 && a == b && b == c) begin
               win  = 1'b1;
               mark = a;
            end
         end
         for (int i = 0; i < 9; i++) if (cells[i] == 0) full = 1'b0;
         if (win) begin
            mWinner = mark;
            mPhase  = PH_DONE;
         end else if (full) begin
            mWinner = 3;
            mPhase  = PH_DONE;
         end else begin
            mTurn  = 1 - mTurn;
            mPhase = PH_PLAY;
         end
         mIdle = 0;
      end else begin
         mIdle = 0;
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".board"},     gameBus.board,      modelBoard());
      checkValue({tag, ".turn"},      gameBus.turn,       mTurn[0]);
      checkValue({tag, ".winner"},    gameBus.winner,     modelWinner());
      checkValue({tag, ".game_over"}, gameBus.game_over,  mPhase == PH_DONE);
      checkValue({tag, ".move_err"},  gameBus.move_err,   mErr);
      checkValue({tag, ".timeout"},   gameBus.timeout,    mTo);
      checkValue({tag, ".ready"},     gameBus.move_ready, (mPhase == PH_PLAY) && !gameBus.new_game);
   endtask

   task automatic applyStimulus(input bit ng, input bit mv, input int idx, input string tag);
      gameBus.new_game   = ng;
      gameBus.move_valid = mv;
      gameBus.move_idx   = 4'(idx);
      @(posedge clk);
      modelStep(ng, mv, idx);
      #1;
      checkOutput(tag);
   endtask

   task automatic playMove(input int idx);
      applyStimulus(1'b0, 1'b1, idx, "move");
      applyStimulus(1'b0, 1'b0, 0, "check");
   endtask

   task automatic startGame();
      applyStimulus(1'b1, 1'b0, 0, "new_game");
   endtask

   int drawSeq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

   initial begin
      bit ng, mv;
      int idx;

      rstN               = 1'b0;
      gameBus.new_game   = 1'b0;
      gameBus.move_valid = 1'b0;
      gameBus.move_idx   = 4'd0;
      modelReset();
      #12;
      checkOutput("reset");
      @(negedge clk);
      rstN = 1'b1;

      $display("[TB] X wins on the top row");
      startGame();
      playMove(0); playMove(3); playMove(1); playMove(4); playMove(2);
      checkValue("row0.winner",    gameBus.winner,      2'b01);
      checkValue("row0.game_over", gameBus.game_over,   1'b1);
      checkValue("row0.board",     gameBus.board[5:0],  6'b010101);

      $display("[TB] O targets an occupied cell");
      startGame();
      playMove(0);
      applyStimulus(1'b0, 1'b1, 0, "occupied");
      checkValue("occupied.err",   gameBus.move_err, 1'b1);
      checkValue("occupied.turn",  gameBus.turn,     1'b1);
      checkValue("occupied.board", gameBus.board,    18'h00001);
      applyStimulus(1'b0, 1'b0, 0, "occupied_after");
      checkValue("occupied.err_pulse", gameBus.move_err, 1'b0);

      $display("[TB] out-of-range cell index");
      applyStimulus(1'b0, 1'b1, 12, "bad_idx");
      checkValue("bad_idx.err",   gameBus.move_err,   1'b1);
      checkValue("bad_idx.ready", gameBus.move_ready, 1'b1);
      checkValue("bad_idx.over",  gameBus.game_over,  1'b0);
      applyStimulus(1'b0, 1'b0, 0, "bad_idx_after");
      checkValue("bad_idx.err_pulse", gameBus.move_err, 1'b0);

      $display("[TB] full board with no line is a draw");
      startGame();
      for (int i = 0; i < 9; i++) playMove(drawSeq[i]);
      checkValue("draw.winner",    gameBus.winner,    2'b10);
      checkValue("draw.game_over", gameBus.game_over, 1'b1);
      applyStimulus(1'b0, 1'b1, 4, "done_ignore");
      checkValue("done_ignore.err", gameBus.move_err, 1'b0);

      $display("[TB] new_game beats a simultaneous legal move");
      startGame();
      playMove(0);
      applyStimulus(1'b1, 1'b1, 4, "ng_prio");
      checkValue("ng_prio.board",  gameBus.board,  18'h0);
      checkValue("ng_prio.turn",   gameBus.turn,   1'b0);
      checkValue("ng_prio.winner", gameBus.winner, 2'b00);

      $display("[TB] reset asserted during CHECK");
      applyStimulus(1'b0, 1'b1, 4, "pre_reset");
      #2;
      rstN = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset");
      checkValue("async_reset.board", gameBus.board, 18'h0);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1'b0, 1'b0, 0, "post_reset");
      checkValue("post_reset.over", gameBus.game_over, 1'b0);

`ifdef GAME_TIMEOUT_EN
      $display("[TB] idle turn forfeit");
      startGame();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0, "idle");
      checkValue("idle3.timeout", gameBus.timeout, 1'b0);
      checkValue("idle3.turn",    gameBus.turn,    1'b0);
      applyStimulus(1'b0, 1'b0, 0, "idle");
      checkValue("idle4.timeout", gameBus.timeout, 1'b1);
      checkValue("idle4.turn",    gameBus.turn,    1'b1);
      applyStimulus(1'b0, 1'b0, 0, "idle");
      checkValue("idle5.timeout", gameBus.timeout, 1'b0);
`endif

      $display("[TB] random play");
      startGame();
      for (int n = 0; n < 600; n++) begin
         if (mPhase == PH_DONE) ng = ($urandom_range(0, 2) == 0);
         else                   ng = ($urandom_range(0, 40) == 0);
         mv = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) idx = int'($urandom_range(9, 15));
         else                           idx = int'($urandom_range(0, 8));
         applyStimulus(ng, mv, idx, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
